// File: rtl/myfft_twiddle_seq.sv
// Twiddle-factor sequencer for the radix-2 FFT engine.
// Walks every stage s and butterfly b of an N = 2^L point transform, issues one twiddle ROM
// read per butterfly and streams the returned words over a valid/ready handshake.
// Build option: define MYFFT_TWSEQ_DIF_EN for decimation-in-frequency address ordering;
// the default build uses decimation-in-time ordering.
module myfft_twiddle_seq #(
  parameter int unsigned word_width = 16,
  parameter int unsigned config_num = 1,
  parameter int unsigned max_log2n  = 7,
  parameter int unsigned max_awidth = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [3:0]              log2n_i,
  input  logic [config_num-1:0]   cfg_sel_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [max_awidth-1:0]   rom_adr_o,
  output logic                    rom_rd_o,
  output logic [config_num-1:0]   rom_cfg_sel_o,
  input  logic [2*word_width-1:0] rom_dat_i,
  output logic [2*word_width-1:0] tw_dat_o,
  output logic                    tw_valid_o,
  input  logic                    tw_ready_i,
  output logic [3:0]              tw_stage_o,
  output logic                    tw_last_o
);

  localparam logic [3:0]            MaxL   = 4'(max_log2n);
  localparam logic [config_num-1:0] SelOne = config_num'(1);
  localparam logic [max_awidth-1:0] BOne   = max_awidth'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                  r_state, w_state_nxt;
  logic [3:0]              r_l;
  logic [3:0]              r_s;
  logic [max_awidth-1:0]   r_b;
  logic [config_num-1:0]   r_sel;
  logic                    r_valid;
  logic                    r_last;
  logic [3:0]              r_stage;
  logic                    r_done;
  logic                    r_err;

  logic                    w_size_ok;
  logic                    w_onehot;
  logic                    w_start_ok;
  logic [3:0]              w_l_m1;
  logic [max_awidth-1:0]   w_bmax;
  logic [max_awidth-1:0]   w_adr;
  logic                    w_b_wrap;
  logic                    w_s_last;
  logic                    w_rd;
  logic                    w_last_rd;
  logic                    w_last_acc;

  assign w_size_ok  = (log2n_i != 4'd0) && (log2n_i <= MaxL);
  assign w_onehot   = (cfg_sel_i != '0) && ((cfg_sel_i & (cfg_sel_i - SelOne)) == '0);
  assign w_start_ok = (r_state == StIdle) && start_i && w_size_ok && w_onehot;

  // Butterfly limit and twiddle exponent for the current (s, b); r_l >= 1 whenever in RUN.
  always_comb begin
    w_l_m1 = r_l - 4'd1;
    w_bmax = max_awidth'((32'd1 << w_l_m1) - 32'd1);
`ifdef MYFFT_TWSEQ_DIF_EN
    w_adr  = (r_b & max_awidth'((32'd1 << (w_l_m1 - r_s)) - 32'd1)) << r_s;
`else
    w_adr  = (r_b & max_awidth'((32'd1 << r_s) - 32'd1)) << (w_l_m1 - r_s);
`endif
  end

  assign w_b_wrap   = (r_b == w_bmax);
  assign w_s_last   = (r_s == w_l_m1);
  // A read refills the output register, so it may only issue when that register is free.
  assign w_rd       = (r_state == StRun) && (!r_valid || tw_ready_i);
  assign w_last_rd  = w_rd && w_b_wrap && w_s_last;
  assign w_last_acc = (r_state == StDrain) && r_valid && r_last && tw_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_nxt = StRun;
      StRun:   if (w_last_rd)  w_state_nxt = StDrain;
      StDrain: if (w_last_acc) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (abort_i) w_state_nxt = StIdle;
  end

  // Counters, latched run parameters and the registered output word qualifiers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_l     <= '0;
      r_s     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_stage <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (abort_i) begin
      r_s     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_stage <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err  <= (r_state == StIdle) && start_i && !(w_size_ok && w_onehot);
      r_done <= w_last_acc;
      if (w_start_ok) begin
        r_l   <= log2n_i;
        r_sel <= cfg_sel_i;
        r_s   <= '0;
        r_b   <= '0;
      end
      if (w_last_acc) r_sel <= '0;
      if (w_rd) begin
        // Counters return to zero after the final read so the address idles at 0.
        if (w_b_wrap) begin
          r_b <= '0;
          r_s <= w_s_last ? 4'd0 : r_s + 4'd1;
        end else begin
          r_b <= r_b + BOne;
        end
        r_valid <= 1'b1;
        r_stage <= r_s;
        r_last  <= w_b_wrap && w_s_last;
      end else if (tw_ready_i) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_stage <= '0;
      end
    end
  end

  assign busy_o        = (r_state != StIdle);
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign rom_adr_o     = (r_state == StRun) ? w_adr : '0;
  assign rom_rd_o      = w_rd;
  assign rom_cfg_sel_o = r_sel;
  assign tw_dat_o      = rom_dat_i;
  assign tw_valid_o    = r_valid;
  assign tw_stage_o    = r_stage;
  assign tw_last_o     = r_last;

endmodule

// File: doc/myfft_twiddle_seq.md
# myfft_twiddle_seq

Twiddle-factor sequencer for the radix-2 FFT engine. It walks all stages and butterflies of an N-point transform and generates the twiddle ROM address for each butterfly. It drives the ROM read enable and configuration select, and streams the resulting twiddle words to the butterfly datapath over a valid/ready handshake. It sits between the FFT control unit (start/done) and the twiddle ROM bank (address/enable/select in, one-cycle registered data out).

## Interface
- `word_width`, 16, real/imag width; twiddle word is `2*word_width`
- `config_num`, 1, number of ROM configurations; width of the one-hot select
- `max_log2n`, 7, largest supported log2(N)
- `max_awidth`, 6, ROM address width; must equal `max_log2n-1`

- `clk_i`, in, 1, clock, rising edge
- `rst_n_i`, in, 1, asynchronous active-low reset
- `start_i`, in, 1, start pulse; sampled only in IDLE
- `abort_i`, in, 1, synchronous abort
- `log2n_i`, in, 4, transform size L for this run; latched at start
- `cfg_sel_i`, in, `config_num`, one-hot ROM configuration; latched at start
- `busy_o`, out, 1, high in RUN or DRAIN
- `done_o`, out, 1, one-cycle pulse after the last twiddle is accepted
- `err_o`, out, 1, one-cycle pulse when a start is rejected
- `rom_adr_o`, out, `max_awidth`, ROM address (twiddle exponent)
- `rom_rd_o`, out, 1, ROM clock enable
- `rom_cfg_sel_o`, out, `config_num`, latched select; zero when idle
- `rom_dat_i`, in, `2*word_width`, ROM q; registered, updates only on cycles with `rom_rd_o` high
- `tw_dat_o`, out, `2*word_width`, equals `rom_dat_i` (combinational pass-through)
- `tw_valid_o`, out, 1, twiddle word valid
- `tw_ready_i`, in, 1, datapath accepts the word
- `tw_stage_o`, out, 4, stage index of the current `tw_dat_o`
- `tw_last_o`, out, 1, high with the final word of the run

## Operation
- States:
  - **IDLE**: no activity.
  - **RUN**: addresses remain to be issued.
  - **DRAIN**: all reads issued, final word not yet accepted.
- **IDLE → RUN:** on `start_i` with `1 <= log2n_i <= max_log2n` and `cfg_sel_i` exactly one-hot.
  - Latch L and the select.
  - Clear stage counter `s` and butterfly counter `b`.
- **Rejected start:** a start with an invalid size or a non-one-hot select pulses `err_o` the next cycle and stays in IDLE.
- **start_i in RUN or DRAIN:** ignored.
- **Read issue:** `rom_rd_o = (state==RUN) && (!tw_valid_o || tw_ready_i)`.
- **On each issued read:**
  - `b` increments.
  - When `b` reaches `2^(L-1)-1`, `b` wraps to 0 and `s` increments.
  - After the read with `s==L-1` and `b==2^(L-1)-1`, go to DRAIN.
- **Address (DIT):** `rom_adr_o = (b mod 2^s) << (L-1-s)`, zero-extended to `max_awidth`.
- **Read count:** total reads = `L * 2^(L-1)`.
- **tw_valid_o:**
  - Set the cycle after a read.
  - Cleared when the word is accepted with no new read in the same cycle.
  - `tw_stage_o` and `tw_last_o` are registered alongside it.
- **Backpressure:** while `tw_valid_o && !tw_ready_i`, `rom_rd_o` is low. The ROM q holds, so `tw_dat_o` stays stable.
- **DRAIN → IDLE:** when the `tw_last_o` word is accepted. `done_o` pulses the following cycle.
- **abort_i:** takes priority over everything.
  - Next cycle: IDLE, `tw_valid_o=0`, `busy_o=0`.
  - No `done_o` pulse.
  - The latched select is cleared.
- **Reset values:**
  - State IDLE.
  - All outputs 0: `busy_o`, `done_o`, `err_o`, `rom_rd_o`, `rom_adr_o`, `rom_cfg_sel_o`, `tw_valid_o`, `tw_stage_o`, `tw_last_o`.
  - Reset asserted mid-run behaves as abort, but asynchronously.

## Timing
- **Start:** `start_i` sampled at edge 0.
  - Cycle 1: RUN, first `rom_rd_o`.
  - Cycle 2: first `tw_valid_o`.
- **Throughput:** with `tw_ready_i` held high, one word per cycle, no bubbles, including across stage boundaries.
- **Run length:** for R reads, the last valid is in cycle R+1 and `done_o` in cycle R+2.
- **Simultaneous accept and read:** `tw_valid_o` stays high and the data advances.

## Configuration
- Macro `MYFFT_TWSEQ_DIF_EN`.
  - Defined: decimation-in-frequency ordering, `rom_adr_o = (b mod 2^(L-1-s)) << s`.
  - Undefined: DIT formula above.
- Counters, handshake and timing are identical in both builds.

## Test plan
- **N=8 DIT, ready=1:** L=3, start at cycle 0 → 12 reads in cycles 1–12.
  - Addresses 0,0,0,0 / 0,2,0,2 / 0,1,2,3.
  - `tw_last_o` in cycle 13, `done_o` in cycle 14.
- **N=8 with `MYFFT_TWSEQ_DIF_EN`:** addresses 0,1,2,3 / 0,2,0,2 / 0,0,0,0, with `tw_stage_o` values 0/1/2.
- **Backpressure, N=16:** toggle `tw_ready_i` randomly → accepted sequence identical to the ready=1 run (32 words).
  - `tw_dat_o` stable while stalled.
  - `rom_rd_o` never high while `valid && !ready`.
- **Bad start:** `log2n_i=0`, `log2n_i=8`, or `cfg_sel_i=2'b11` → `err_o` pulse, `busy_o` stays 0, no reads.
- **Abort at the 5th read of N=8 run** → IDLE next cycle, `tw_valid_o=0`, no `done_o`. A fresh start then replays the full sequence from address 0.
- **L=1 and async reset mid-run:**
  - L=1: exactly one read of address 0, with `tw_last_o` set.
  - `rst_n_i` low mid-run: all outputs 0 immediately.
